// File: rtl/riscv_pkg.sv
// Shared RV32I front-end types: widths, the canonical NOP, fetch FSM states and the IF/ID payload.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        KILL
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and IMEM.
interface fetch_unit_if;
    import riscv_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [ILEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer that parks a fetched word (and its PC) while IF/ID is frozen.
module fetch_hold_buf
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [ILEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, keeps at most one IMEM request outstanding and fills the IF/ID register,
// honouring load-use stalls and EX redirects without losing or duplicating fetched words.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            pcsrc_ex,
    input  logic [XLEN-1:0] pc_target_ex,
    fetch_unit_if.master    imem,
    output logic [ILEN-1:0] instr_if_id,
    output logic [XLEN-1:0] pc_if_id,
    output logic [XLEN-1:0] pc4_if_id,
    output logic            valid_if_id
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    if_id_t          if_id_q, if_id_d;

    logic            req_c;
    logic            rsp_c;
    logic            hb_load, hb_clear, hb_valid;
    logic [ILEN-1:0] hb_instr;
    logic [XLEN-1:0] hb_pc;

    // Redirect targets are word aligned, so the two LSBs are never consumed.
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^pc_target_ex[1:0];

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (hb_load),
        .clear      (hb_clear),
        .load_instr (imem.rdata),
        .load_pc    (req_pc_q),
        .valid      (hb_valid),
        .instr      (hb_instr),
        .pc         (hb_pc)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if_id_d  = if_id_q;
        hb_load  = 1'b0;
        hb_clear = 1'b0;
        req_c    = 1'b0;
        rsp_c    = (state_q == WAIT) && imem.rvalid;

        // WAIT may re-request in the response cycle to sustain one instruction per cycle.
        case (state_q)
            REQ:     req_c = 1'b1;
            WAIT:    req_c = imem.rvalid && !stall;
            default: req_c = 1'b0;
        endcase
        req_c = req_c && !rst && !pcsrc_ex && !hb_valid;

        if (req_c && imem.gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
        end

        case (state_q)
            REQ:     if (req_c && imem.gnt) state_d = WAIT;
            WAIT: begin
                if (pcsrc_ex)          state_d = imem.rvalid ? REQ : KILL;
                else if (imem.rvalid)  state_d = (req_c && imem.gnt) ? WAIT : REQ;
            end
            KILL:    if (imem.rvalid) state_d = REQ;
            default: state_d = REQ;
        endcase

        if (pcsrc_ex) begin
            pc_d = {pc_target_ex[XLEN-1:2], 2'b00};
        end

        // IF/ID update: redirect beats stall, a parked word beats a fresh response.
        if (pcsrc_ex) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
            hb_clear      = 1'b1;
        end else if (stall) begin
            hb_load = rsp_c;
        end else if (hb_valid) begin
            if_id_d  = '{instr: hb_instr, pc: hb_pc, pc4: hb_pc + XLEN'(4), valid: 1'b1};
            hb_clear = 1'b1;
        end else if (rsp_c) begin
            if_id_d = '{instr: imem.rdata, pc: req_pc_q, pc4: req_pc_q + XLEN'(4), valid: 1'b1};
        end else begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            if_id_q  <= '{instr: NOP_INSTR, pc: '0, pc4: '0, valid: 1'b0};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            if_id_q  <= if_id_d;
        end
    end

    assign imem.req    = req_c;
    assign imem.addr   = pc_q;
    assign instr_if_id = if_id_q.instr;
    assign pc_if_id    = if_id_q.pc;
    assign pc4_if_id   = if_id_q.pc4;
    assign valid_if_id = if_id_q.valid;

    // A response with nothing outstanding is an IMEM protocol violation.
    rvalid_in_req_a : assert property (@(posedge clk) disable iff (rst)
        !(state_q == REQ && imem.rvalid));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic checked against a stream model.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic clk;
    logic rst;
    logic stall;
    logic pcsrc_ex;
    logic [XLEN-1:0] pc_target_ex;
    logic [ILEN-1:0] instr_if_id;
    logic [XLEN-1:0] pc_if_id;
    logic [XLEN-1:0] pc4_if_id;
    logic            valid_if_id;

    logic [ILEN-1:0] instr2;
    logic [XLEN-1:0] pc2;
    logic [XLEN-1:0] pc4_2;
    logic            valid2;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .pcsrc_ex(pcsrc_ex), .pc_target_ex(pc_target_ex),
        .imem(bus.master), .instr_if_id(instr_if_id), .pc_if_id(pc_if_id),
        .pc4_if_id(pc4_if_id), .valid_if_id(valid_if_id)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .pcsrc_ex(1'b0), .pc_target_ex(32'h0),
        .imem(bus2.master), .instr_if_id(instr2), .pc_if_id(pc2),
        .pc4_if_id(pc4_2), .valid_if_id(valid2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endfunction

    // Zero-wait memory for the wrap-around instance: always grants, answers one cycle later.
    assign bus2.gnt = 1'b1;
    always_ff @(posedge clk) begin
        bus2.rvalid <= bus2.req && !rst;
        bus2.rdata  <= mem_word(bus2.addr);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int delivered = 0;

    logic nxt_rst, nxt_stall, nxt_pcsrc, nxt_gnt;
    logic [31:0] nxt_tgt;
    int lat = 1;
    logic prev_rst = 1'b1, prev_stall = 1'b0, prev_pcsrc = 1'b0;

    logic        pend_v = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] exp_fetch = '0;
    logic [31:0] exp_next = '0;
    if_id_t      exp_ifid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // IF/ID as seen after the last edge, judged by the inputs applied in the previous cycle.
    task automatic check_if_id();
        if (prev_rst) begin
            check("rst_valid", 32'(valid_if_id), 32'd0);
            check("rst_instr", instr_if_id, NOP_INSTR);
            check("rst_pc", pc_if_id, 32'd0);
            check("rst_pc4", pc4_if_id, 32'd0);
            exp_ifid = '{instr: NOP_INSTR, pc: '0, pc4: '0, valid: 1'b0};
        end else if (prev_pcsrc) begin
            check("flush_valid", 32'(valid_if_id), 32'd0);
            check("flush_instr", instr_if_id, NOP_INSTR);
            check("flush_pc", pc_if_id, exp_ifid.pc);
            exp_ifid.valid = 1'b0;
            exp_ifid.instr = NOP_INSTR;
        end else if (prev_stall) begin
            check("stall_valid", 32'(valid_if_id), 32'(exp_ifid.valid));
            check("stall_instr", instr_if_id, exp_ifid.instr);
            check("stall_pc", pc_if_id, exp_ifid.pc);
            check("stall_pc4", pc4_if_id, exp_ifid.pc4);
        end else if (valid_if_id) begin
            check("stream_pc", pc_if_id, exp_next);
            check("stream_instr", instr_if_id, mem_word(exp_next));
            check("stream_pc4", pc4_if_id, exp_next + 32'd4);
            exp_ifid = '{instr: mem_word(exp_next), pc: exp_next, pc4: exp_next + 32'd4, valid: 1'b1};
            exp_next = exp_next + 32'd4;
            delivered++;
        end else begin
            check("bubble_instr", instr_if_id, NOP_INSTR);
            check("bubble_pc", pc_if_id, exp_ifid.pc);
            exp_ifid.valid = 1'b0;
            exp_ifid.instr = NOP_INSTR;
        end
    endtask

    // One clock: drive just after the edge, sample mid-cycle; returns at the sample point.
    task automatic step();
        @(posedge clk);
        #1;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        if (pend_v) begin
            if (pend_cnt <= 1) begin
                bus.rvalid = 1'b1;
                bus.rdata  = mem_word(pend_addr);
                pend_v     = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        rst          = nxt_rst;
        stall        = nxt_stall;
        pcsrc_ex     = nxt_pcsrc;
        pc_target_ex = nxt_tgt;
        bus.gnt      = nxt_gnt;
        #4;
        check_if_id();
        if (rst) begin
            check("req_in_rst", 32'(bus.req), 32'd0);
            exp_fetch = 32'h0;
            exp_next  = 32'h0;
        end else if (pcsrc_ex) begin
            check("req_on_redirect", 32'(bus.req), 32'd0);
            exp_fetch = pc_target_ex & 32'hFFFF_FFFC;
            exp_next  = exp_fetch;
        end else if (bus.req && bus.gnt) begin
            check("fetch_addr", bus.addr, exp_fetch);
            check("one_outstanding", 32'(pend_v), 32'd0);
            pend_v    = 1'b1;
            pend_cnt  = lat;
            pend_addr = bus.addr;
            exp_fetch = exp_fetch + 32'd4;
        end
        prev_rst   = rst;
        prev_stall = stall;
        prev_pcsrc = pcsrc_ex;
    endtask

    task automatic do_reset(input int n);
        nxt_rst = 1'b1; nxt_stall = 1'b0; nxt_pcsrc = 1'b0; nxt_gnt = 1'b0;
        repeat (n) step();
        nxt_rst = 1'b0;
        pend_v  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pcsrc_ex = 1'b0; pc_target_ex = '0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        nxt_rst = 1'b1; nxt_stall = 1'b0; nxt_pcsrc = 1'b0; nxt_gnt = 1'b0; nxt_tgt = '0;
        exp_ifid = '{instr: NOP_INSTR, pc: '0, pc4: '0, valid: 1'b0};

        // Streaming at one instruction per cycle, then a 3-cycle stall with a word in flight.
        do_reset(2);
        nxt_gnt = 1'b1; lat = 1;
        step();
        check("s0_req", 32'(bus.req), 32'd1);
        check("s0_addr", bus.addr, 32'h0);
        check("wrap_addr0", bus2.addr, 32'hFFFF_FFFC);
        step();
        check("s1_bubble", 32'(valid_if_id), 32'd0);
        check("wrap_addr1", bus2.addr, 32'h0000_0000);
        step();
        check("s2_valid", 32'(valid_if_id), 32'd1);
        check("s2_pc", pc_if_id, 32'h0);
        check("wrap_pc", pc2, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4_2, 32'h0);
        check("wrap_valid", 32'(valid2), 32'd1);
        check("wrap_instr", instr2, mem_word(32'hFFFF_FFFC));
        step();
        check("s3_pc", pc_if_id, 32'h4);
        step();
        check("s4_pc", pc_if_id, 32'h8);
        nxt_stall = 1'b1;
        step();
        check("stall_req0", 32'(bus.req), 32'd0);
        step();
        check("stall_req1", 32'(bus.req), 32'd0);
        step();
        nxt_stall = 1'b0;
        step();
        check("frozen_pc", pc_if_id, 32'hC);
        check("frozen_valid", 32'(valid_if_id), 32'd1);
        step();
        check("release_pc", pc_if_id, 32'h10);
        check("release_addr", bus.addr, 32'h14);

        // Redirect while a slow response is outstanding: stale word dropped, refetch at 0x100.
        do_reset(2);
        nxt_gnt = 1'b1; lat = 3;
        step();
        nxt_pcsrc = 1'b1; nxt_tgt = 32'h103;
        step();
        nxt_pcsrc = 1'b0; lat = 1;
        step();
        check("kill_valid", 32'(valid_if_id), 32'd0);
        check("kill_instr", instr_if_id, NOP_INSTR);
        check("kill_req", 32'(bus.req), 32'd0);
        step();
        step();
        check("redirect_req", 32'(bus.req), 32'd1);
        check("redirect_addr", bus.addr, 32'h100);
        step();
        step();
        check("redirect_pc", pc_if_id, 32'h100);

        // Redirect coinciding with a stall: the flush wins.
        do_reset(2);
        nxt_gnt = 1'b1; lat = 1;
        repeat (3) step();
        nxt_stall = 1'b1; nxt_pcsrc = 1'b1; nxt_tgt = 32'h200;
        step();
        nxt_stall = 1'b0; nxt_pcsrc = 1'b0;
        step();
        check("flush_over_stall_v", 32'(valid_if_id), 32'd0);
        check("flush_over_stall_i", instr_if_id, NOP_INSTR);
        step();
        step();
        check("after_flush_pc", pc_if_id, 32'h200);

        // Grant withheld for four cycles, then a response three cycles late.
        do_reset(2);
        nxt_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("nogrant_req", 32'(bus.req), 32'd1);
            check("nogrant_addr", bus.addr, 32'h0);
        end
        nxt_gnt = 1'b1; lat = 3;
        step();
        nxt_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("late_bubble", 32'(valid_if_id), 32'd0);
        end
        step();
        check("late_pc", pc_if_id, 32'h0);
        check("late_valid", 32'(valid_if_id), 32'd1);

        // Reset while waiting on a response fetched from 0x40: that word must never surface.
        do_reset(2);
        nxt_pcsrc = 1'b1; nxt_tgt = 32'h40;
        step();
        nxt_pcsrc = 1'b0; nxt_gnt = 1'b1; lat = 3;
        step();
        do_reset(3);
        nxt_gnt = 1'b1; lat = 1;
        step();
        check("post_rst_addr", bus.addr, 32'h0);
        step();
        step();
        check("post_rst_pc", pc_if_id, 32'h0);
        check("post_rst_instr", instr_if_id, mem_word(32'h0));

        // Randomized traffic against the in-order stream model.
        begin
            int base;
            base = delivered;
            for (int c = 0; c < 4000; c++) begin
                if (($urandom % 500) == 0) begin
                    do_reset(3);
                end
                nxt_gnt   = (($urandom % 100) < 75);
                nxt_stall = (($urandom % 100) < 20);
                nxt_pcsrc = (($urandom % 100) < 5);
                nxt_tgt   = $urandom & 32'h0000_0FFF;
                lat       = int'($urandom_range(1, 3));
                step();
            end
            check("progress", 32'((delivered - base) > 200), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
